// File: rtl/vga_timing_gen.sv
// Pixel-rate video timing generator: hsync/vsync/blank, beam coordinates,
// line/frame strobes and an optional 8-bar colour test image, all registered together.
module vga_timing_gen #(
  parameter int c_resolution_x      = 640,
  parameter int c_hsync_front_porch = 16,
  parameter int c_hsync_pulse       = 96,
  parameter int c_hsync_back_porch  = 48,
  parameter int c_resolution_y      = 480,
  parameter int c_vsync_front_porch = 10,
  parameter int c_vsync_pulse       = 2,
  parameter int c_vsync_back_porch  = 33,
  parameter int c_bits_x            = 10,
  parameter int c_bits_y            = 10,
  parameter int c_hsync_polarity    = 0,
  parameter int c_vsync_polarity    = 0,
  parameter int c_test_pattern      = 1
) (
  input  logic                clk_pixel,
  input  logic                resetn,
  input  logic                clk_pixel_ena,
  output logic                o_hsync,
  output logic                o_vsync,
  output logic                o_blank,
  output logic                o_hblank,
  output logic                o_vblank,
  output logic [c_bits_x-1:0] o_beam_x,
  output logic [c_bits_y-1:0] o_beam_y,
  output logic                o_line_start,
  output logic                o_frame_start,
  output logic [7:0]          o_r,
  output logic [7:0]          o_g,
  output logic [7:0]          o_b
);

  localparam int c_ht    = c_resolution_x + c_hsync_front_porch + c_hsync_pulse + c_hsync_back_porch;
  localparam int c_vt    = c_resolution_y + c_vsync_front_porch + c_vsync_pulse + c_vsync_back_porch;
  localparam int c_bar_w = c_resolution_x / 8;

  localparam logic [c_bits_x-1:0] c_x_last     = c_bits_x'(c_ht - 1);
  localparam logic [c_bits_x-1:0] c_x_active   = c_bits_x'(c_resolution_x);
  localparam logic [c_bits_x-1:0] c_x_hs_start = c_bits_x'(c_resolution_x + c_hsync_front_porch);
  localparam logic [c_bits_x-1:0] c_x_hs_end   = c_bits_x'(c_resolution_x + c_hsync_front_porch + c_hsync_pulse);
  localparam logic [c_bits_x-1:0] c_bar_last   = c_bits_x'(c_bar_w - 1);

  localparam logic [c_bits_y-1:0] c_y_last     = c_bits_y'(c_vt - 1);
  localparam logic [c_bits_y-1:0] c_y_active   = c_bits_y'(c_resolution_y);
  localparam logic [c_bits_y-1:0] c_y_vs_start = c_bits_y'(c_resolution_y + c_vsync_front_porch);
  localparam logic [c_bits_y-1:0] c_y_vs_end   = c_bits_y'(c_resolution_y + c_vsync_front_porch + c_vsync_pulse);

  localparam logic c_hs_on   = (c_hsync_polarity != 0);
  localparam logic c_vs_on   = (c_vsync_polarity != 0);
  localparam logic c_bars_en = (c_test_pattern != 0);

  // Position counters point at the pixel the next enabled cycle will present.
  logic [c_bits_x-1:0] x_q, x_d;
  logic [c_bits_y-1:0] y_q, y_d;
  logic [2:0]          bar_n_q, bar_n_d;
  logic [c_bits_x-1:0] bar_cnt_q, bar_cnt_d;

  logic                hsync_q, hsync_d;
  logic                vsync_q, vsync_d;
  logic                hblank_q, hblank_d;
  logic                vblank_q, vblank_d;
  logic                blank_q, blank_d;
  logic [c_bits_x-1:0] beam_x_q, beam_x_d;
  logic [c_bits_y-1:0] beam_y_q, beam_y_d;
  logic                line_start_q, line_start_d;
  logic                frame_start_q, frame_start_d;
  logic [7:0]          r_q, r_d;
  logic [7:0]          g_q, g_d;
  logic [7:0]          b_q, b_d;

  logic       hact, vact;
  logic [2:0] bar_m;

  always_comb begin
    // NOTE: every signal gets a hold default first, so no path through this block infers a latch.
    x_d           = x_q;
    y_d           = y_q;
    bar_n_d       = bar_n_q;
    bar_cnt_d     = bar_cnt_q;
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    hblank_d      = hblank_q;
    vblank_d      = vblank_q;
    blank_d       = blank_q;
    beam_x_d      = beam_x_q;
    beam_y_d      = beam_y_q;
    line_start_d  = line_start_q;
    frame_start_d = frame_start_q;
    r_d           = r_q;
    g_d           = g_q;
    b_d           = b_q;
    hact          = (x_q < c_x_active);
    vact          = (y_q < c_y_active);
    bar_m         = ~bar_n_q;

    if (clk_pixel_ena) begin
      // Every output is derived from the same (x_q, y_q), so nothing skews.
      beam_x_d      = x_q;
      beam_y_d      = y_q;
      hblank_d      = !hact;
      vblank_d      = !vact;
      blank_d       = !(hact && vact);
      hsync_d       = (x_q >= c_x_hs_start && x_q < c_x_hs_end) ? c_hs_on : ~c_hs_on;
      vsync_d       = (y_q >= c_y_vs_start && y_q < c_y_vs_end) ? c_vs_on : ~c_vs_on;
      line_start_d  = (x_q == '0);
      frame_start_d = (x_q == '0) && (y_q == '0);
      if (c_bars_en && hact && vact) begin
        r_d = {8{bar_m[1]}};
        g_d = {8{bar_m[2]}};
        b_d = {8{bar_m[0]}};
      end else begin
        r_d = '0;
        g_d = '0;
        b_d = '0;
      end

      if (x_q == c_x_last) begin
        x_d       = '0;
        bar_n_d   = '0;
        bar_cnt_d = '0;
        y_d       = (y_q == c_y_last) ? '0 : y_q + 1'b1;
      end else begin
        x_d = x_q + 1'b1;
        // Bar index steps every c_bar_w pixels and saturates, so remainder pixels stay in bar 7.
        if (bar_cnt_q == c_bar_last) begin
          bar_cnt_d = '0;
          if (bar_n_q != 3'd7) bar_n_d = bar_n_q + 3'd1;
        end else begin
          bar_cnt_d = bar_cnt_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_pixel) begin
    // NOTE: state uses non-blocking assignments so all flops update from pre-edge values.
    if (!resetn) begin
      x_q           <= '0;
      y_q           <= '0;
      bar_n_q       <= '0;
      bar_cnt_q     <= '0;
      hsync_q       <= ~c_hs_on;
      vsync_q       <= ~c_vs_on;
      hblank_q      <= 1'b1;
      vblank_q      <= 1'b1;
      blank_q       <= 1'b1;
      beam_x_q      <= '0;
      beam_y_q      <= '0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      r_q           <= '0;
      g_q           <= '0;
      b_q           <= '0;
    end else begin
      x_q           <= x_d;
      y_q           <= y_d;
      bar_n_q       <= bar_n_d;
      bar_cnt_q     <= bar_cnt_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      hblank_q      <= hblank_d;
      vblank_q      <= vblank_d;
      blank_q       <= blank_d;
      beam_x_q      <= beam_x_d;
      beam_y_q      <= beam_y_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      r_q           <= r_d;
      g_q           <= g_d;
      b_q           <= b_d;
    end
  end

  assign o_hsync       = hsync_q;
  assign o_vsync       = vsync_q;
  assign o_hblank      = hblank_q;
  assign o_vblank      = vblank_q;
  assign o_blank       = blank_q;
  assign o_beam_x      = beam_x_q;
  assign o_beam_y      = beam_y_q;
  assign o_line_start  = line_start_q;
  assign o_frame_start = frame_start_q;
  assign o_r           = r_q;
  assign o_g           = g_q;
  assign o_b           = b_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen: three configurations driven with shared random
// enable/reset stimulus, compared every clock against an arithmetic timing model.
module tb_vga_timing_gen;

  typedef struct packed {
    logic        hs, vs, blank, hblank, vblank;
    logic [15:0] bx, by;
    logic        ls, fs;
    logic [7:0]  r, g, b;
  } out_t;

  typedef struct {
    int rx, hfp, hp, hbp, ry, vfp, vp, vbp;
    bit hpol, vpol, tp;
  } cfg_t;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic clk_pixel_ena = 1'b0;
  always #5 clk = ~clk;

  // DUT0: defaults. DUT1: small frame, active-high syncs, bar remainder of 4.
  // DUT2: small frame, bars disabled, odd width.
  logic hs0, vs0, bl0, hb0, vb0, ls0, fs0;
  logic [9:0] bx0, by0;
  logic [7:0] r0, g0, b0;
  logic hs1, vs1, bl1, hb1, vb1, ls1, fs1;
  logic [5:0] bx1;
  logic [3:0] by1;
  logic [7:0] r1, g1, b1;
  logic hs2, vs2, bl2, hb2, vb2, ls2, fs2;
  logic [5:0] bx2;
  logic [3:0] by2;
  logic [7:0] r2, g2, b2;

  vga_timing_gen u_dut0 (
    .clk_pixel(clk), .resetn(resetn), .clk_pixel_ena(clk_pixel_ena),
    .o_hsync(hs0), .o_vsync(vs0), .o_blank(bl0), .o_hblank(hb0), .o_vblank(vb0),
    .o_beam_x(bx0), .o_beam_y(by0), .o_line_start(ls0), .o_frame_start(fs0),
    .o_r(r0), .o_g(g0), .o_b(b0)
  );

  vga_timing_gen #(
    .c_resolution_x(44), .c_hsync_front_porch(3), .c_hsync_pulse(5), .c_hsync_back_porch(4),
    .c_resolution_y(6), .c_vsync_front_porch(2), .c_vsync_pulse(2), .c_vsync_back_porch(3),
    .c_bits_x(6), .c_bits_y(4), .c_hsync_polarity(1), .c_vsync_polarity(1), .c_test_pattern(1)
  ) u_dut1 (
    .clk_pixel(clk), .resetn(resetn), .clk_pixel_ena(clk_pixel_ena),
    .o_hsync(hs1), .o_vsync(vs1), .o_blank(bl1), .o_hblank(hb1), .o_vblank(vb1),
    .o_beam_x(bx1), .o_beam_y(by1), .o_line_start(ls1), .o_frame_start(fs1),
    .o_r(r1), .o_g(g1), .o_b(b1)
  );

  vga_timing_gen #(
    .c_resolution_x(43), .c_hsync_front_porch(3), .c_hsync_pulse(5), .c_hsync_back_porch(4),
    .c_resolution_y(6), .c_vsync_front_porch(2), .c_vsync_pulse(2), .c_vsync_back_porch(3),
    .c_bits_x(6), .c_bits_y(4), .c_hsync_polarity(0), .c_vsync_polarity(0), .c_test_pattern(0)
  ) u_dut2 (
    .clk_pixel(clk), .resetn(resetn), .clk_pixel_ena(clk_pixel_ena),
    .o_hsync(hs2), .o_vsync(vs2), .o_blank(bl2), .o_hblank(hb2), .o_vblank(vb2),
    .o_beam_x(bx2), .o_beam_y(by2), .o_line_start(ls2), .o_frame_start(fs2),
    .o_r(r2), .o_g(g2), .o_b(b2)
  );

  out_t act0, act1, act2;
  assign act0 = {hs0, vs0, bl0, hb0, vb0, 16'(bx0), 16'(by0), ls0, fs0, r0, g0, b0};
  assign act1 = {hs1, vs1, bl1, hb1, vb1, 16'(bx1), 16'(by1), ls1, fs1, r1, g1, b1};
  assign act2 = {hs2, vs2, bl2, hb2, vb2, 16'(bx2), 16'(by2), ls2, fs2, r2, g2, b2};

  // ---------------- reference model ----------------
  cfg_t cfg [3];
  int   nx  [3];
  int   ny  [3];
  out_t cur [3];
  out_t q0[$], q1[$], q2[$];
  int   checks = 0;
  int   failures = 0;

  function automatic out_t reset_out(cfg_t c);
    out_t o = '0;
    o.hs = ~c.hpol;
    o.vs = ~c.vpol;
    o.blank = 1'b1;
    o.hblank = 1'b1;
    o.vblank = 1'b1;
    return o;
  endfunction

  function automatic out_t pix_out(cfg_t c, int x, int y);
    out_t o = '0;
    int n;
    bit [2:0] m;
    o.hblank = (x >= c.rx);
    o.vblank = (y >= c.ry);
    o.blank  = o.hblank | o.vblank;
    o.hs = (x >= c.rx + c.hfp && x < c.rx + c.hfp + c.hp) ? c.hpol : ~c.hpol;
    o.vs = (y >= c.ry + c.vfp && y < c.ry + c.vfp + c.vp) ? c.vpol : ~c.vpol;
    o.bx = 16'(x);
    o.by = 16'(y);
    o.ls = (x == 0);
    o.fs = (x == 0) && (y == 0);
    n = x / (c.rx / 8);
    if (n > 7) n = 7;
    m = 3'(7 - n);
    if (c.tp && !o.blank) begin
      o.r = {8{m[1]}};
      o.g = {8{m[2]}};
      o.b = {8{m[0]}};
    end
    return o;
  endfunction

  task automatic model_edge(input bit r, input bit e);
    for (int i = 0; i < 3; i++) begin
      if (!r) begin
        cur[i] = reset_out(cfg[i]);
        nx[i] = 0;
        ny[i] = 0;
      end else if (e) begin
        cur[i] = pix_out(cfg[i], nx[i], ny[i]);
        nx[i]++;
        if (nx[i] == cfg[i].rx + cfg[i].hfp + cfg[i].hp + cfg[i].hbp) begin
          nx[i] = 0;
          ny[i]++;
          if (ny[i] == cfg[i].ry + cfg[i].vfp + cfg[i].vp + cfg[i].vbp) ny[i] = 0;
        end
      end
    end
    q0.push_back(cur[0]);
    q1.push_back(cur[1]);
    q2.push_back(cur[2]);
  endtask

  // Inputs change on the falling edge; the expected state after the next rising edge is queued.
  task automatic step(input bit r, input bit e);
    @(negedge clk);
    resetn = r;
    clk_pixel_ena = e;
    model_edge(r, e);
  endtask

  task automatic check(input string name, input out_t got, input out_t exp);
    checks++;
    if (got !== exp) begin
      failures++;
      if (failures <= 20)
        $display("FAIL %s t=%0t: got beam=(%0d,%0d) hs=%b vs=%b bl=%b hb=%b vb=%b ls=%b fs=%b rgb=%h%h%h, expected beam=(%0d,%0d) hs=%b vs=%b bl=%b hb=%b vb=%b ls=%b fs=%b rgb=%h%h%h",
                 name, $time, got.bx, got.by, got.hs, got.vs, got.blank, got.hblank, got.vblank,
                 got.ls, got.fs, got.r, got.g, got.b, exp.bx, exp.by, exp.hs, exp.vs, exp.blank,
                 exp.hblank, exp.vblank, exp.ls, exp.fs, exp.r, exp.g, exp.b);
    end
  endtask

  // Monitor: one expected entry per rising edge, sampled just after the edge.
  initial begin
    out_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q0.size() > 0) begin
        e = q0.pop_front();
        check("dut0_default", act0, e);
        e = q1.pop_front();
        check("dut1_small_pol1", act1, e);
        e = q2.pop_front();
        check("dut2_small_nobars", act2, e);
      end
    end
  end

  initial begin
    cfg[0] = '{rx: 640, hfp: 16, hp: 96, hbp: 48, ry: 480, vfp: 10, vp: 2, vbp: 33, hpol: 0, vpol: 0, tp: 1};
    cfg[1] = '{rx: 44,  hfp: 3,  hp: 5,  hbp: 4,  ry: 6,   vfp: 2,  vp: 2, vbp: 3,  hpol: 1, vpol: 1, tp: 1};
    cfg[2] = '{rx: 43,  hfp: 3,  hp: 5,  hbp: 4,  ry: 6,   vfp: 2,  vp: 2, vbp: 3,  hpol: 0, vpol: 0, tp: 0};

    // Reset with enable both low and high, then free-run for several lines/frames.
    step(0, 0);
    step(0, 1);
    step(0, 0);
    for (int i = 0; i < 2500; i++) step(1, 1);

    // Enable toggling 1,0,1,0: outputs must hold on disabled cycles.
    for (int i = 0; i < 1800; i++) step(1, (i % 2) == 0);

    // Random enable with occasional 3-clock mid-frame resets.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 399) == 0) begin
        for (int k = 0; k < 3; k++) step(0, 1'($urandom_range(0, 1)));
      end else begin
        step(1, $urandom_range(0, 3) != 0);
      end
    end

    // Reset mid-line, then a full default line from (0,0) to cover the bar boundaries.
    for (int k = 0; k < 3; k++) step(0, 1);
    for (int i = 0; i < 900; i++) step(1, 1);

    @(posedge clk);
    #2;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
